// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks the EX/MEM word, runs the data-memory handshake,
// resolves branch/jump redirect and registers the MEM/WB word. Optional abort: MEM_TIMEOUT_EN.
module mem_stage
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 16
)
`endif
(
    input  logic         clk,
    input  logic         clr,
    input  logic [132:0] in,
    output logic         dm_req,
    output logic         dm_we,
    output logic [31:0]  dm_addr,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ready,
    output logic         stall,
    output logic         redirect,
    output logic [31:0]  pc_target,
    output logic [70:0]  out,
    output logic         mem_err
);

    typedef struct packed {
        logic [25:0] pc_jump;
        logic [31:0] pc_branch;
        logic [31:0] write_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
        logic        jump;
        logic        branch_eq;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        zero;
    } ex_mem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    ex_mem_t     em;
    state_t      state;
    logic        memop;
    logic [31:0] rd;

    assign em = ex_mem_t'(in);

    always_comb begin
        memop     = em.mem_to_reg | em.mem_write;
        dm_req    = memop & (state != ERR);
        stall     = dm_req & ~dm_ready;
        dm_we     = em.mem_write;
        dm_addr   = em.alu_out;
        dm_wdata  = em.write_data;
        rd        = (dm_req & dm_ready & em.mem_to_reg) ? dm_rdata : 32'd0;
        redirect  = (em.branch_eq & em.zero) | em.jump;
        pc_target = em.jump ? {em.pc_branch[31:28], em.pc_jump, 2'b00} : em.pc_branch;
    end

`ifdef MEM_TIMEOUT_EN
    logic [4:0] cnt;
    logic       err_q;

    assign mem_err = err_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            out   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            // a stalled cycle writes a bubble so the pending load is retired once
            out   <= stall ? '0 : {rd, em.alu_out, em.write_reg, em.mem_to_reg, em.reg_write};
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (stall) state <= WAIT;
                    cnt <= '0;
                end
                WAIT: begin
                    if (dm_ready) begin
                        state <= IDLE;
                    end else if (cnt == 5'(TIMEOUT_CYC - 1)) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign mem_err = 1'b0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            out   <= '0;
        end else begin
            // a stalled cycle writes a bubble so the pending load is retired once
            out <= stall ? '0 : {rd, em.alu_out, em.write_reg, em.mem_to_reg, em.reg_write};
            case (state)
                IDLE:    if (stall) state <= WAIT;
                WAIT:    if (dm_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake/stall, MEM/WB capture, redirect,
// reset behaviour and (with MEM_TIMEOUT_EN) the abort pulse.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         clr;
    logic [132:0] in;
    logic         dm_req, dm_we, dm_ready, stall, redirect, mem_err;
    logic [31:0]  dm_addr, dm_wdata, dm_rdata, pc_target;
    logic [70:0]  out;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .clr(clr), .in(in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall(stall), .redirect(redirect), .pc_target(pc_target),
        .out(out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [132:0] got, input logic [132:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [132:0] word(
        input logic zero, rw, m2r, mw, beq, j,
        input logic [4:0] wr, input logic [31:0] alu, wd, pcb, input logic [25:0] pcj);
        return {pcj, pcb, wd, alu, wr, j, beq, mw, m2r, rw, zero};
    endfunction

    function automatic logic [70:0] wb(
        input logic [31:0] rdat, alu, input logic [4:0] wr, input logic m2r, rw);
        return {rdat, alu, wr, m2r, rw};
    endfunction

    initial begin
        clr = 1'b1; in = '0; dm_ready = 1'b0; dm_rdata = '0;
        tick();
        tick();
        chk("rst_out", out, '0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_req", dm_req, 0);
        clr = 1'b0;

        // zero-wait load
        in = word(0, 1, 1, 0, 0, 0, 5'd5, 32'h40, 32'h0, 32'h0, 26'h0);
        dm_ready = 1'b1; dm_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_req", dm_req, 1);
        chk("t1_stall", stall, 0);
        chk("t1_addr", dm_addr, 32'h40);
        chk("t1_we", dm_we, 0);
        tick();
        chk("t1_out", out, wb(32'hDEADBEEF, 32'h40, 5'd5, 1, 1));
        in = '0; dm_ready = 1'b0;

        // load with 3 wait cycles
        in = word(0, 1, 1, 0, 0, 0, 5'd6, 32'h44, 32'h0, 32'h0, 26'h0);
        dm_rdata = 32'h11112222;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_stall%0d", i), stall, 1);
            chk($sformatf("t2_req%0d", i), dm_req, 1);
            tick();
            chk($sformatf("t2_bubble%0d", i), out, '0);
        end
        dm_ready = 1'b1; dm_rdata = 32'hCAFEF00D;
        #1;
        chk("t2_stall_rdy", stall, 0);
        tick();
        chk("t2_out", out, wb(32'hCAFEF00D, 32'h44, 5'd6, 1, 1));
        in = '0; dm_ready = 1'b0;
        tick();
        chk("t2_once", out, '0);

        // store
        in = word(0, 0, 0, 1, 0, 0, 5'd0, 32'h80, 32'h12345678, 32'h0, 26'h0);
        dm_ready = 1'b1; dm_rdata = 32'hFFFFFFFF;
        #1;
        chk("t3_we", dm_we, 1);
        chk("t3_wdata", dm_wdata, 32'h12345678);
        chk("t3_req", dm_req, 1);
        chk("t3_stall", stall, 0);
        tick();
        chk("t3_out", out, wb(32'h0, 32'h80, 5'd0, 0, 0));

        // ALU op with stray dm_ready: ready ignored, no read data
        in = word(0, 1, 0, 0, 0, 0, 5'd7, 32'h99, 32'h0, 32'h0, 26'h0);
        dm_ready = 1'b1; dm_rdata = 32'hAAAA5555;
        #1;
        chk("alu_req", dm_req, 0);
        tick();
        chk("alu_out", out, wb(32'h0, 32'h99, 5'd7, 0, 1));
        dm_ready = 1'b0;

        // branch
        in = word(1, 0, 0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h00400020, 26'h0);
        #1;
        chk("t4_redir", redirect, 1);
        chk("t4_target", pc_target, 32'h00400020);
        chk("t4_stall", stall, 0);
        in = word(0, 0, 0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h00400020, 26'h0);
        #1;
        chk("t4_nottaken", redirect, 0);

        // jump, then jump+taken branch
        in = word(0, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h0, 32'h30000000, 26'h0000010);
        #1;
        chk("t5_redir", redirect, 1);
        chk("t5_target", pc_target, 32'h30000040);
        in = word(1, 0, 0, 0, 1, 1, 5'd0, 32'h0, 32'h0, 32'h50000100, 26'h0000004);
        #1;
        chk("t5_jwins", pc_target, 32'h50000010);
        tick();

        // reset mid-WAIT
        in = word(0, 1, 1, 0, 0, 0, 5'd9, 32'h60, 32'h0, 32'h0, 26'h0);
        dm_ready = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        chk("t6_out", out, '0);
        // clr together with dm_ready: clr wins
        dm_ready = 1'b1; dm_rdata = 32'h0BADF00D;
        tick();
        chk("t6_clr_rdy", out, '0);
        clr = 1'b0;
        #1;
        chk("t6_nostall", stall, 0);
        tick();
        chk("t6_idle_load", out, wb(32'h0BADF00D, 32'h60, 5'd9, 1, 1));
        in = '0; dm_ready = 1'b0;
        tick();

`ifdef MEM_TIMEOUT_EN
        in = word(0, 1, 1, 0, 0, 0, 5'd3, 32'h70, 32'h0, 32'h0, 26'h0);
        dm_rdata = 32'h77777777;
        #1;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("to_stall%0d", i), stall, 1);
            chk($sformatf("to_noerr%0d", i), mem_err, 0);
            tick();
        end
        chk("to_err", mem_err, 1);
        chk("to_stall_drop", stall, 0);
        chk("to_req_drop", dm_req, 0);
        tick();
        chk("to_err_once", mem_err, 0);
        chk("to_out", out, wb(32'h0, 32'h70, 5'd3, 1, 1));
        in = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
